player_ctrl: RTL
================

// Module: player_ctrl
// PURPOSE
//  Command scheduler between the debounced key pulse sources and the note playback datapath.
//  Arbitrates simultaneous key pulses and enforces a post-command lockout.
//  Runs the STOP/PLAY/PAUSE state machine and drives song selection, play enable and restart to the note sequencer.
// PARAMETERS
//  SONG_NUM      4            number of songs stored; song_sel wraps within 0..SONG_NUM-1
//  SONG_W        2            width of song_sel; must satisfy 2**SONG_W >= SONG_NUM
//  LOCK_CNT_MAX  20'd500_000  lockout length in sys_clk cycles after an accepted key command (10 ms @ 50 MHz)
// PORTS
//  sys_clk       in   1       system clock, all logic on posedge
//  sys_rst       in   1       synchronous reset, active-high
//  key_play      in   1       1-cycle pulse, debounced play/pause key
//  key_next      in   1       1-cycle pulse, debounced next-song key
//  key_prev      in   1       1-cycle pulse, debounced previous-song key
//  song_end      in   1       1-cycle pulse from the note sequencer: last note of current song finished
//  play_en       out  1       1 = sequencer advances notes / drives buzzer; 0 = hold address, silence
//  song_sel      out  SONG_W  index of current song
//  song_restart  out  1       1-cycle pulse: sequencer resets note address to start of song_sel
//  state         out  2       2'b00 STOP, 2'b01 PLAY, 2'b10 PAUSE (2'b11 never driven)
//  lock_busy     out  1       1 while lockout counter is running (key pulses ignored)
// BEHAVIOUR
//  Reset (sys_rst=1 at a clock edge): state=STOP, play_en=0, song_sel=0, song_restart=0, lock_busy=0, lock counter=0.
//  Reset mid-operation overrides all inputs in that cycle; any pending lockout is cleared.
//  All outputs are registered; the response to an input sampled at edge N is visible after edge N (1-cycle latency).
//  Arbitration: key pulses in the same cycle -> fixed priority play > next > prev.
//  Only the winning key is accepted; losing keys are dropped, not queued.
//  Lockout: an accepted key loads the counter. lock_busy=1 for exactly LOCK_CNT_MAX cycles, starting the cycle after acceptance.
//  Key pulses arriving while lock_busy=1 are ignored. song_end is never subject to lockout and does not start it.
//  FSM (accepted key -> action):
//   STOP  + play : ->PLAY, song_restart pulse, play_en=1
//   PLAY  + play : ->PAUSE, play_en=0, no restart (note address held)
//   PAUSE + play : ->PLAY, play_en=1, no restart (resume)
//   any   + next : song_sel = (song_sel==SONG_NUM-1) ? 0 : song_sel+1; song_restart pulse; state unchanged
//   any   + prev : song_sel = (song_sel==0) ? SONG_NUM-1 : song_sel-1; song_restart pulse; state unchanged
//   PLAY  + song_end : see CONFIGURATION; song_end in STOP or PAUSE is ignored
//  play_en == (state==PLAY) in every cycle.
//  Simultaneous accepted key and song_end in the same cycle: the key is executed and song_end is dropped.
//  song_restart is never high for 2 consecutive cycles from a single event.
// CONFIGURATION
//  Macro PLAYER_AUTO_NEXT_EN
//   defined    : PLAY + song_end -> song_sel advances as for next (with wrap), song_restart pulse, stays PLAY
//   undefined  : PLAY + song_end -> STOP, play_en=0, song_sel unchanged, no restart pulse
// TESTING
//  1. After reset, pulse key_play -> next cycle state=01, play_en=1, song_restart=1 for 1 cycle, lock_busy=1 for 500_000 cycles.
//  2. key_play, key_next and key_prev pulsed in the same cycle from STOP -> only play executed.
//     song_sel stays 0; a key_next pulsed 100 cycles later is ignored.
//  3. song_sel=3 (SONG_NUM=4) in PAUSE: key_next -> song_sel=0, restart pulse, state stays 10.
//     After lockout, key_prev -> song_sel=3.
//  4. PLAY, song_sel=1, song_end pulse -> with PLAYER_AUTO_NEXT_EN: song_sel=2, restart, state 01.
//     Without the macro: state=00, play_en=0, song_sel=1.
//  5. song_end and accepted key_play in the same cycle during PLAY -> state=PAUSE, song_sel unchanged, no restart.
//  6. sys_rst asserted for 1 cycle during lockout while in PLAY with song_sel=2
//     -> all outputs return to reset values; an immediate key_play is accepted.

Source files
------------

// File: rtl/player_ctrl.sv
// Key-command scheduler for the note player: arbitration, post-command lockout and STOP/PLAY/PAUSE control.
// Optional build macro PLAYER_AUTO_NEXT_EN: song_end during PLAY advances to the next song instead of stopping.
//
// state    | meaning
// ST_STOP  | idle, note address held, buzzer silent
// ST_PLAY  | sequencer advancing notes
// ST_PAUSE | playback suspended, note address held for resume
module player_ctrl #(
    parameter int unsigned SONG_NUM     = 4,
    parameter int unsigned SONG_W       = 2,
    parameter logic [19:0] LOCK_CNT_MAX = 20'd500_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_play,
    input  logic              key_next,
    input  logic              key_prev,
    input  logic              song_end,
    output logic              play_en,
    output logic [SONG_W-1:0] song_sel,
    output logic              song_restart,
    output logic [1:0]        state,
    output logic              lock_busy
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam logic [SONG_W-1:0] SEL_LAST = SONG_W'(SONG_NUM - 1);

    state_e            state_q, state_d;
    logic [SONG_W-1:0] song_sel_q, song_sel_d;
    logic              restart_q, restart_d;
    logic              play_en_q, play_en_d;
    logic              busy_q, busy_d;
    logic [19:0]       lock_cnt_q, lock_cnt_d;

    logic key_ok, acc_play, acc_next, acc_prev, any_key, end_ev;

    // Fixed priority play > next > prev; losers are simply dropped.
    always_comb begin
        key_ok   = (lock_cnt_q == 20'd0);
        acc_play = key_ok & key_play;
        acc_next = key_ok & ~key_play & key_next;
        acc_prev = key_ok & ~key_play & ~key_next & key_prev;
        any_key  = acc_play | acc_next | acc_prev;
        end_ev   = song_end & ~any_key & (state_q == ST_PLAY);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_STOP;
            song_sel_q <= '0;
            restart_q  <= 1'b0;
            play_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            lock_cnt_q <= 20'd0;
        end else begin
            state_q    <= state_d;
            song_sel_q <= song_sel_d;
            restart_q  <= restart_d;
            play_en_q  <= play_en_d;
            busy_q     <= busy_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc_play) begin
            case (state_q)
                ST_STOP:  state_d = ST_PLAY;
                ST_PLAY:  state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_PLAY;
                default:  state_d = ST_STOP;
            endcase
        end else if (end_ev) begin
`ifdef PLAYER_AUTO_NEXT_EN
            state_d = ST_PLAY;
`else
            state_d = ST_STOP;
`endif
        end
    end

    always_comb begin
        song_sel_d = song_sel_q;
        restart_d  = 1'b0;
        play_en_d  = (state_d == ST_PLAY);
        if (acc_play) begin
            restart_d = (state_q == ST_STOP);
        end else if (acc_next) begin
            song_sel_d = (song_sel_q == SEL_LAST) ? '0 : song_sel_q + 1'b1;
            restart_d  = 1'b1;
        end else if (acc_prev) begin
            song_sel_d = (song_sel_q == '0) ? SEL_LAST : song_sel_q - 1'b1;
            restart_d  = 1'b1;
        end else if (end_ev) begin
`ifdef PLAYER_AUTO_NEXT_EN
            song_sel_d = (song_sel_q == SEL_LAST) ? '0 : song_sel_q + 1'b1;
            restart_d  = 1'b1;
`endif
        end

        // Load on acceptance, then count down to zero; busy shows the loaded/remaining value.
        if (any_key)
            lock_cnt_d = LOCK_CNT_MAX;
        else if (lock_cnt_q != 20'd0)
            lock_cnt_d = lock_cnt_q - 20'd1;
        else
            lock_cnt_d = 20'd0;
        busy_d = (lock_cnt_d != 20'd0);
    end

    assign state        = state_q;
    assign song_sel     = song_sel_q;
    assign song_restart = restart_q;
    assign play_en      = play_en_q;
    assign lock_busy    = busy_q;

endmodule
